// File: rtl/ysyx_24090003_ctrl_pkg.sv
// Shared types and constants for the EXU sequencer: state encoding, reset PC, PC increment.
package ysyx_24090003_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_FWAIT  = 4'd2,
        S_EXEC   = 4'd3,
        S_COMMIT = 4'd4,
        S_MREQ   = 4'd5,
        S_MWAIT  = 4'd6,
        S_WB     = 4'd7,
        S_HALT   = 4'd8
    } ctrl_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // States in which the sequencer is blocked on the memory bus.
    function automatic logic is_mem_wait(input ctrl_state_e s);
        return (s == S_FETCH) || (s == S_FWAIT) || (s == S_MREQ) || (s == S_MWAIT);
    endfunction

endpackage

// File: rtl/ysyx_24090003_wait_timer.sv
// 8-bit wait counter: clears on request, counts while enabled, saturates once expired.
module ysyx_24090003_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q >= 8'(MEM_TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_24090003_exu_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC and the shared memory port, and
// gates EXU write-back so architectural state only changes in the WB cycle.
module ysyx_24090003_exu_ctrl
    import ysyx_24090003_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          MEM_TIMEOUT = 255
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        run,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic        exu_valid,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_ebreak,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_npc,
    input  logic        ex_npc_we,
    input  logic        rf_we_in,
    output logic        rf_we,
    output logic        load_sel,
    output logic [31:0] load_data,
    output logic [31:0] pc,
    output logic        halt,
    output logic        err,
    output logic [31:0] instr_cnt,
    output logic [3:0]  dbg_state
);

    ctrl_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic        err_q, err_d;
    logic        tmo_expired;

    ysyx_24090003_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i    (cpu_clk),
        .rst_i    (rst),
        .clr_i    (state_d != state_q),
        .en_i     (is_mem_wait(state_q)),
        .expired_o(tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        load_data_d = load_data_q;
        instr_cnt_d = instr_cnt_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_FWAIT;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_FWAIT: begin
                if (mem_rvalid) begin
                    inst_d  = mem_rdata;
                    state_d = S_EXEC;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_EXEC: state_d = S_COMMIT;
            S_COMMIT: begin
                // ebreak retires without a register write; a misaligned target never retires.
                if (dec_ebreak) begin
                    instr_cnt_d = instr_cnt_q + 32'd1;
                    state_d     = S_HALT;
                end else if (ex_npc_we && (ex_npc[1:0] != 2'b00)) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else if (dec_load || dec_store) begin
                    state_d = S_MREQ;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MREQ: begin
                if (mem_ready) begin
                    state_d = S_MWAIT;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_MWAIT: begin
                if (mem_rvalid) begin
                    if (dec_load) load_data_d = mem_rdata;
                    state_d = S_WB;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                pc_d        = ex_npc_we ? ex_npc : pc_q + PC_STEP;
                instr_cnt_d = instr_cnt_q + 32'd1;
                state_d     = run ? S_FETCH : S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= 32'd0;
            load_data_q <= 32'd0;
            instr_cnt_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            load_data_q <= load_data_d;
            instr_cnt_q <= instr_cnt_d;
            err_q       <= err_d;
        end
    end

    // Bus handshake: a request transfers when mem_req & mem_ready at a rising edge; the
    // response (read data or write ack) is mem_rvalid in a later cycle. mem_req is a
    // pure state decode, so it never depends combinationally on mem_ready or mem_rvalid.
    assign mem_req   = (state_q == S_FETCH) || (state_q == S_MREQ);
    assign mem_we    = (state_q == S_MREQ) && dec_store;
    assign mem_addr  = (state_q == S_FETCH) ? pc_q :
                       (state_q == S_MREQ)  ? ex_addr : 32'd0;
    assign mem_wdata = (state_q == S_MREQ) ? ex_wdata : 32'd0;

    assign exu_valid = (state_q == S_EXEC);
    assign rf_we     = (state_q == S_WB) && rf_we_in;
    assign load_sel  = (state_q == S_WB) && dec_load;
    assign halt      = (state_q == S_HALT);
    assign err       = err_q;
    assign inst      = inst_q;
    assign load_data = load_data_q;
    assign pc        = pc_q;
    assign instr_cnt = instr_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_24090003_exu_ctrl.sv
// Bench for the EXU sequencer: a bus/EXU responder, fetch/data address and write-back scoreboards.
module tb_ysyx_24090003_exu_ctrl;
    import ysyx_24090003_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_EBRK = 3;

    logic        cpu_clk, rst, run;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, inst;
    logic        exu_valid, dec_load, dec_store, dec_ebreak;
    logic [31:0] ex_addr, ex_wdata, ex_npc;
    logic        ex_npc_we, rf_we_in, rf_we, load_sel, halt, err;
    logic [31:0] load_data, pc, instr_cnt;
    logic [3:0]  dbg_state;

    ysyx_24090003_exu_ctrl #(
        .RESET_PC   (RST_PC),
        .MEM_TIMEOUT(255)
    ) u_dut (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .run       (run),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .inst      (inst),
        .exu_valid (exu_valid),
        .dec_load  (dec_load),
        .dec_store (dec_store),
        .dec_ebreak(dec_ebreak),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_npc    (ex_npc),
        .ex_npc_we (ex_npc_we),
        .rf_we_in  (rf_we_in),
        .rf_we     (rf_we),
        .load_sel  (load_sel),
        .load_data (load_data),
        .pc        (pc),
        .halt      (halt),
        .err       (err),
        .instr_cnt (instr_cnt),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];      // expected bus request addresses, in order
    logic [32:0] exp_wb_q[$];   // expected {load_sel, load_data} per rf_we pulse
    logic [31:0] inst_word;
    logic [31:0] model_pc, model_cnt;
    int r_cycles, r_rf_cnt, r_rf_cyc, r_exu_cnt, r_exu_cyc;

    // ---------------- clock / reset ----------------
    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic clear_inputs();
        run = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        dec_load = 1'b0; dec_store = 1'b0; dec_ebreak = 1'b0;
        ex_addr = 32'h0; ex_wdata = 32'h0; ex_npc = 32'h0; ex_npc_we = 1'b0; rf_we_in = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_pc = RST_PC;
        model_cnt = 32'd0;
    endtask

    // ---------------- driver: one instruction, DUT must be in FETCH ----------------
    task automatic exec_instr(input int kind, input logic [31:0] addr, input logic [31:0] rd,
                              input logic [31:0] npc, input logic npc_we, input logic rfw,
                              input int fdly, input int ddly, input bit no_rsp, input bit abort);
        int wait_cnt;
        int req_idx;
        bit rsp_pend;
        bit done;
        logic [31:0] rsp_data, wd, a;
        logic [32:0] e;
        logic exp_we;
        wait_cnt = 0; req_idx = 0; rsp_pend = 0; done = 0; rsp_data = 32'h0;
        wd = addr ^ 32'hFFFF_0000;
        dec_load = (kind == K_LOAD); dec_store = (kind == K_STORE); dec_ebreak = (kind == K_EBRK);
        ex_addr = addr; ex_wdata = wd; ex_npc = npc; ex_npc_we = npc_we; rf_we_in = rfw;
        r_cycles = 0; r_rf_cnt = 0; r_rf_cyc = 0; r_exu_cnt = 0; r_exu_cyc = 0;
        for (int c = 1; c <= 600 && !done; c++) begin
            r_cycles = c;
            if (exu_valid) begin r_exu_cnt++; r_exu_cyc = c; end
            if (rf_we) begin
                r_rf_cnt++; r_rf_cyc = c;
                checks++;
                if (exp_wb_q.size() == 0) begin
                    failures++;
                    $display("FAIL wb_unexpected: rf_we=1 at cycle %0d, required no write-back", c);
                end else begin
                    e = exp_wb_q.pop_front();
                    if (load_sel !== e[32] || (e[32] && load_data !== e[31:0])) begin
                        failures++;
                        $display("FAIL wb_data: load_sel=%0b load_data=%h, required load_sel=%0b load_data=%h",
                                 load_sel, load_data, e[32], e[31:0]);
                    end
                end
            end
            if (halt) begin
                done = 1;
            end else if (abort && dbg_state == S_MWAIT) begin
                rst = 1'b1;
                #2;
                done = 1;
            end else begin
                if (dbg_state == S_WB) done = 1;
                mem_rvalid = rsp_pend;
                mem_rdata = rsp_pend ? rsp_data : 32'h0;
                rsp_pend = 0;
                mem_ready = 1'b0;
                if (mem_req) begin
                    if (wait_cnt >= ((req_idx == 0) ? fdly : ddly)) begin
                        mem_ready = 1'b1;
                        rsp_pend = !(no_rsp && req_idx == 0);
                        rsp_data = (req_idx == 0) ? inst_word : rd;
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL bus_addr: request to %h, required no request", mem_addr);
                        end else begin
                            a = exp_q.pop_front();
                            if (mem_addr !== a) begin
                                failures++;
                                $display("FAIL bus_addr: mem_addr=%h required %h", mem_addr, a);
                            end
                        end
                        exp_we = (req_idx != 0) && (kind == K_STORE);
                        checks++;
                        if (mem_we !== exp_we) begin
                            failures++;
                            $display("FAIL bus_we: mem_we=%0b required %0b", mem_we, exp_we);
                        end
                        if (exp_we) begin
                            checks++;
                            if (mem_wdata !== wd) begin
                                failures++;
                                $display("FAIL bus_wdata: mem_wdata=%h required %h", mem_wdata, wd);
                            end
                        end
                        req_idx++;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
                tick();
            end
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL instr_bound: no WB or halt within 600 cycles, state=%0d", dbg_state);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (dbg_state !== S_IDLE || pc !== RST_PC || inst !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: state=%0d pc=%h inst=%h, required 0 %h 0", dbg_state, pc, inst, RST_PC);
        end
        checks++;
        if (load_data !== 32'h0 || instr_cnt !== 32'h0) begin
            failures++;
            $display("FAIL reset_regs: load_data=%h instr_cnt=%h, required 0 0", load_data, instr_cnt);
        end
        checks++;
        if ({mem_req, mem_we, exu_valid, rf_we, load_sel, halt, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_strobes: %b required 0000000", {mem_req, mem_we, exu_valid, rf_we, load_sel, halt, err});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: mem_addr=%h mem_wdata=%h, required 0 0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        model_pc = RST_PC;
        model_cnt = 32'd0;
        repeat (3) tick();
        checks++;
        if (mem_req !== 1'b0 || dbg_state !== S_IDLE) begin
            failures++;
            $display("FAIL idle_no_run: mem_req=%0b state=%0d, required 0 IDLE", mem_req, dbg_state);
        end
    endtask

    task automatic test_alu();
        inst_word = 32'h0010_0093;
        run = 1'b1;
        tick();
        exp_q.push_back(model_pc);
        exp_wb_q.push_back({1'b0, 32'h0});
        exec_instr(K_ALU, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0, 0, 0, 0);
        model_pc = model_pc + 32'd4; model_cnt++;
        checks++;
        if (r_cycles !== 5 || r_exu_cyc !== 3 || r_exu_cnt !== 1) begin
            failures++;
            $display("FAIL alu_timing: cycles=%0d exu_cyc=%0d exu_cnt=%0d, required 5 3 1", r_cycles, r_exu_cyc, r_exu_cnt);
        end
        checks++;
        if (r_rf_cyc !== 5 || r_rf_cnt !== 1) begin
            failures++;
            $display("FAIL alu_rf_we: rf_cyc=%0d rf_cnt=%0d, required 5 1", r_rf_cyc, r_rf_cnt);
        end
        checks++;
        if (pc !== 32'h8000_0004 || instr_cnt !== 32'd1 || inst !== inst_word) begin
            failures++;
            $display("FAIL alu_commit: pc=%h cnt=%0d inst=%h, required 80000004 1 %h", pc, instr_cnt, inst, inst_word);
        end
    endtask

    task automatic test_load();
        inst_word = 32'h0000_2083;
        exp_q.push_back(model_pc);
        exp_q.push_back(32'h8000_1000);
        exp_wb_q.push_back({1'b1, 32'hDEAD_BEEF});
        exec_instr(K_LOAD, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 0, 3, 0, 0);
        model_pc = model_pc + 32'd4; model_cnt++;
        checks++;
        if (r_cycles !== 10 || r_rf_cnt !== 1 || load_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL load: cycles=%0d rf_cnt=%0d load_data=%h, required 10 1 deadbeef", r_cycles, r_rf_cnt, load_data);
        end
        checks++;
        if (pc !== model_pc || instr_cnt !== model_cnt) begin
            failures++;
            $display("FAIL load_commit: pc=%h cnt=%0d, required %h %0d", pc, instr_cnt, model_pc, model_cnt);
        end
    endtask

    task automatic test_store();
        exp_q.push_back(model_pc);
        exp_q.push_back(32'h8000_1040);
        exec_instr(K_STORE, 32'h8000_1040, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1, 0, 0, 0);
        model_pc = model_pc + 32'd4; model_cnt++;
        checks++;
        if (r_cycles !== 8 || r_rf_cnt !== 0 || load_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL store: cycles=%0d rf_cnt=%0d load_data=%h, required 8 0 deadbeef", r_cycles, r_rf_cnt, load_data);
        end
        checks++;
        if (pc !== model_pc || instr_cnt !== model_cnt) begin
            failures++;
            $display("FAIL store_commit: pc=%h cnt=%0d, required %h %0d", pc, instr_cnt, model_pc, model_cnt);
        end
    endtask

    task automatic test_jump();
        exp_q.push_back(model_pc);
        exp_wb_q.push_back({1'b0, 32'h0});
        exec_instr(K_ALU, 32'h0, 32'h0, 32'h8000_0100, 1'b1, 1'b1, 0, 0, 0, 0);
        model_pc = 32'h8000_0100; model_cnt++;
        checks++;
        if (pc !== 32'h8000_0100) begin
            failures++;
            $display("FAIL jump_pc: pc=%h required 80000100", pc);
        end
        exp_q.push_back(model_pc);
        exec_instr(K_ALU, 32'h0, 32'h0, 32'h8000_0200, 1'b0, 1'b0, 0, 0, 0, 0);
        model_pc = model_pc + 32'd4; model_cnt++;
        checks++;
        if (pc !== model_pc || r_rf_cnt !== 0) begin
            failures++;
            $display("FAIL jump_next: pc=%h rf_cnt=%0d, required %h 0", pc, r_rf_cnt, model_pc);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            int kind, fd, dd, exp_cyc;
            logic jw, rfw;
            logic [31:0] npc, a, rd;
            kind = $urandom_range(0, 2);
            fd = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            jw = (kind == K_ALU) && ($urandom_range(0, 1) == 1);
            rfw = (kind != K_STORE) && ($urandom_range(0, 1) == 1);
            npc = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
            a = 32'h8000_2000 + ($urandom_range(0, 255) << 2);
            rd = $urandom;
            inst_word = $urandom;
            exp_q.push_back(model_pc);
            if (kind != K_ALU) exp_q.push_back(a);
            if (rfw) exp_wb_q.push_back({kind == K_LOAD, (kind == K_LOAD) ? rd : 32'h0});
            exec_instr(kind, a, rd, npc, jw, rfw, fd, dd, 0, 0);
            exp_cyc = 5 + fd + ((kind != K_ALU) ? 2 + dd : 0);
            model_pc = jw ? npc : model_pc + 32'd4;
            model_cnt++;
            checks++;
            if (r_cycles !== exp_cyc || pc !== model_pc) begin
                failures++;
                $display("FAIL b2b_%0d: cycles=%0d pc=%h, required %0d %h", i, r_cycles, pc, exp_cyc, model_pc);
            end
        end
        checks++;
        if (instr_cnt !== model_cnt) begin
            failures++;
            $display("FAIL b2b_count: instr_cnt=%0d required %0d", instr_cnt, model_cnt);
        end
    endtask

    task automatic test_run_drop();
        int viol;
        viol = 0;
        run = 1'b0;
        exp_q.push_back(model_pc);
        exec_instr(K_ALU, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0, 0, 0);
        model_pc = model_pc + 32'd4; model_cnt++;
        repeat (4) begin
            if (mem_req || dbg_state != S_IDLE) viol++;
            tick();
        end
        checks++;
        if (viol !== 0 || pc !== model_pc || instr_cnt !== model_cnt) begin
            failures++;
            $display("FAIL run_drop: idle_viol=%0d pc=%h cnt=%0d, required 0 %h %0d", viol, pc, instr_cnt, model_pc, model_cnt);
        end
        run = 1'b1;
        tick();
    endtask

    task automatic test_misaligned();
        exp_q.push_back(model_pc);
        exec_instr(K_ALU, 32'h0, 32'h0, 32'h8000_0102, 1'b1, 1'b1, 0, 0, 0, 0);
        checks++;
        if (halt !== 1'b1 || err !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_flags: halt=%0b err=%0b, required 1 1", halt, err);
        end
        checks++;
        if (pc !== model_pc || instr_cnt !== model_cnt || r_rf_cnt !== 0) begin
            failures++;
            $display("FAIL misaligned_state: pc=%h cnt=%0d rf_cnt=%0d, required %h %0d 0", pc, instr_cnt, r_rf_cnt, model_pc, model_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run = 1'b1;
        tick();
        exp_q.push_back(RST_PC);
        exec_instr(K_ALU, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0, 0, 1, 0);
        checks++;
        if (halt !== 1'b1 || err !== 1'b1 || r_exu_cnt !== 0) begin
            failures++;
            $display("FAIL timeout_flags: halt=%0b err=%0b exu_cnt=%0d, required 1 1 0", halt, err, r_exu_cnt);
        end
        checks++;
        if (r_cycles < 256 || r_cycles > 260 || instr_cnt !== 32'd0) begin
            failures++;
            $display("FAIL timeout_span: halt at cycle %0d cnt=%0d, required 256..260 0", r_cycles, instr_cnt);
        end
    endtask

    task automatic test_ebreak();
        int viol;
        viol = 0;
        do_reset();
        run = 1'b1;
        tick();
        exp_q.push_back(RST_PC);
        exec_instr(K_EBRK, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0, 0, 0, 0);
        checks++;
        if (halt !== 1'b1 || err !== 1'b0 || r_rf_cnt !== 0 || instr_cnt !== 32'd1) begin
            failures++;
            $display("FAIL ebreak: halt=%0b err=%0b rf_cnt=%0d cnt=%0d, required 1 0 0 1", halt, err, r_rf_cnt, instr_cnt);
        end
        repeat (20) begin
            run = 1'b1;
            mem_ready = 1'b1;
            mem_rvalid = ($urandom_range(0, 1) == 1);
            mem_rdata = $urandom;
            tick();
            if (mem_req || exu_valid || rf_we || !halt) viol++;
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        checks++;
        if (viol !== 0 || instr_cnt !== 32'd1) begin
            failures++;
            $display("FAIL halt_sticky: viol=%0d cnt=%0d, required 0 1", viol, instr_cnt);
        end
    endtask

    task automatic test_reset_mwait();
        int viol;
        viol = 0;
        do_reset();
        run = 1'b1;
        tick();
        exp_q.push_back(RST_PC);
        exp_q.push_back(32'h8000_3000);
        exec_instr(K_LOAD, 32'h8000_3000, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 0, 0, 0, 1);
        checks++;
        if (rst !== 1'b1 || dbg_state !== S_IDLE || pc !== RST_PC || load_data !== 32'h0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: rst=%0b state=%0d pc=%h load_data=%h mem_req=%0b, required 1 IDLE %h 0 0",
                     rst, dbg_state, pc, load_data, mem_req, RST_PC);
        end
        tick();
        rst = 1'b0;
        run = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        repeat (3) begin
            if (rf_we || mem_req || dbg_state != S_IDLE) viol++;
            tick();
        end
        checks++;
        if (viol !== 0 || load_data !== 32'h0 || pc !== RST_PC || instr_cnt !== 32'd0) begin
            failures++;
            $display("FAIL late_rvalid: viol=%0d load_data=%h pc=%h cnt=%0d, required 0 0 %h 0", viol, load_data, pc, instr_cnt, RST_PC);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        inst_word = 32'h0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_jump();
        test_back_to_back();
        test_run_drop();
        test_misaligned();
        test_timeout();
        test_ebreak();
        test_reset_mwait();
        checks++;
        if (exp_q.size() !== 0 || exp_wb_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d addresses and %0d write-backs left, required 0 0", exp_q.size(), exp_wb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
